// File: rtl/edge_gen_pkg.sv
// Shared definitions for the edge pattern generator: FSM encoding and
// default field widths.
package edge_gen_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_REP_W = 8;
endpackage

// File: rtl/edge_gen_cnt.sv
// Loadable down-counter; tc flags when the count sits at TC_VAL.
module edge_gen_cnt #(
    parameter int             W      = 8,
    parameter logic [W-1:0]   TC_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= cnt - W'(1);
    end

    assign tc = (cnt == TC_VAL);
endmodule

// File: rtl/edge_pattern_gen.sv
// Burst level-waveform generator: N pulses of programmed high/low length,
// with registered level, edge strobes and status outputs.
module edge_pattern_gen
    import edge_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [REP_W-1:0] repeat_n,
    output logic             dout,
    output logic             rise_strb,
    output logic             fall_strb,
    output logic             busy,
    output logic             done,
    output logic             err
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] high_q, low_q;
    logic             latch;
    logic             dur_load, dur_en, dur_tc;
    logic [CNT_W-1:0] dur_val;
    logic             rep_load, rep_en, rep_last;
    logic             dout_d, rise_d, fall_d, busy_d, done_d, err_d;
    logic             fields_ok;

    assign fields_ok = (high_len != '0) && (low_len != '0) && (repeat_n != '0);

    // One duration counter serves both phases; it is reloaded on each phase change.
    edge_gen_cnt #(.W(CNT_W), .TC_VAL('0)) u_dur (
        .clk(clk), .rst(rst), .load(dur_load), .load_val(dur_val),
        .en(dur_en), .tc(dur_tc)
    );

    // Pulse counter holds pulses still owed including the current one,
    // so the last pulse is the one that ends with the count at 1.
    edge_gen_cnt #(.W(REP_W), .TC_VAL(REP_W'(1))) u_rep (
        .clk(clk), .rst(rst), .load(rep_load), .load_val(repeat_n),
        .en(rep_en), .tc(rep_last)
    );

    always_comb begin
        state_d  = state_q;
        latch    = 1'b0;
        dur_load = 1'b0;
        dur_val  = '0;
        dur_en   = 1'b0;
        rep_load = 1'b0;
        rep_en   = 1'b0;
        dout_d   = 1'b0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (fields_ok) begin
                        latch    = 1'b1;
                        state_d  = HIGH;
                        dur_load = 1'b1;
                        dur_val  = high_len - CNT_W'(1);
                        rep_load = 1'b1;
                        dout_d   = 1'b1;
                        rise_d   = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HIGH, LOW: begin
                if (stop) begin
                    state_d = IDLE;
                    fall_d  = dout;
                end else if (!dur_tc) begin
                    dur_en = 1'b1;
                    dout_d = (state_q == HIGH);
                    busy_d = 1'b1;
                end else if (state_q == HIGH) begin
                    state_d  = LOW;
                    dur_load = 1'b1;
                    dur_val  = low_q - CNT_W'(1);
                    fall_d   = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    rep_en = 1'b1;
                    if (rep_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = HIGH;
                        dur_load = 1'b1;
                        dur_val  = high_q - CNT_W'(1);
                        dout_d   = 1'b1;
                        rise_d   = 1'b1;
                        busy_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            high_q    <= '0;
            low_q     <= '0;
            dout      <= 1'b0;
            rise_strb <= 1'b0;
            fall_strb <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (latch) begin
                high_q <= high_len;
                low_q  <= low_len;
            end
            dout      <= dout_d;
            rise_strb <= rise_d;
            fall_strb <= fall_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end
endmodule

// File: tb/tb_edge_pattern_gen.sv
// Directed bench for edge_pattern_gen: per-cycle vector table plus
// hand-written abort, back-to-back/loopback and max-length sequences.
module tb_edge_pattern_gen;
    logic       clk = 1'b0;
    logic       rst, start, stop;
    logic [7:0] high_len, low_len, repeat_n;
    logic       dout, rise_strb, fall_strb, busy, done, err;
    logic [5:0] o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    edge_pattern_gen #(.CNT_W(8), .REP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .high_len(high_len), .low_len(low_len), .repeat_n(repeat_n),
        .dout(dout), .rise_strb(rise_strb), .fall_strb(fall_strb),
        .busy(busy), .done(done), .err(err)
    );

    assign o = {dout, rise_strb, fall_strb, busy, done, err};

    // Registered edge detector fed by dout.
    logic d1, det_rise, det_fall;
    always_ff @(posedge clk) begin
        if (rst) begin
            d1 <= 1'b0; det_rise <= 1'b0; det_fall <= 1'b0;
        end else begin
            d1       <= dout;
            det_rise <= dout & ~d1;
            det_fall <= ~dout & d1;
        end
    end

    typedef struct {
        logic       rst, start, stop;
        logic [7:0] h, l, n;
        logic [5:0] want;   // {dout,rise,fall,busy,done,err} in the next cycle
        string      name;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic p,
                                input int h, input int l, input int n,
                                input logic [5:0] want, input string name);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p;
        v.h = 8'(h); v.l = 8'(l); v.n = 8'(n);
        v.want = want; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic go(input int h, input int l, input int n);
        high_len = 8'(h); low_len = 8'(l); repeat_n = 8'(n);
        start = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        high_len = 8'd0; low_len = 8'd0; repeat_n = 8'd0;

        // Power-on reset
        add(1,0,0, 0,0,0, 6'b000000, "reset");
        add(1,0,0, 0,0,0, 6'b000000, "reset");
        // Reset for 3 cycles in the middle of a burst, then a clean burst
        add(0,1,0, 4,4,3, 6'b110100, "rst_mid_start");
        add(0,0,0, 4,4,3, 6'b100100, "rst_mid_high");
        add(0,0,0, 4,4,3, 6'b100100, "rst_mid_high");
        for (int i = 0; i < 3; i++) add(1,0,0, 4,4,3, 6'b000000, "rst_mid_hold");
        add(0,0,0, 0,0,0, 6'b000000, "rst_after");
        add(0,1,0, 2,3,1, 6'b110100, "post_rst_burst");
        add(0,0,0, 2,3,1, 6'b100100, "post_rst_burst");
        add(0,0,0, 2,3,1, 6'b001100, "post_rst_burst");
        add(0,0,0, 2,3,1, 6'b000100, "post_rst_burst");
        add(0,0,0, 2,3,1, 6'b000100, "post_rst_burst");
        add(0,0,0, 2,3,1, 6'b000010, "post_rst_done");
        add(0,0,0, 2,3,1, 6'b000000, "post_rst_idle");
        // Basic H=2 L=3 N=2; a second start with other fields mid-burst is ignored
        add(0,1,0, 2,3,2, 6'b110100, "basic");
        add(0,1,0, 7,7,7, 6'b100100, "basic_busy_start");
        add(0,0,0, 9,9,9, 6'b001100, "basic");
        add(0,0,0, 0,0,0, 6'b000100, "basic");
        add(0,0,0, 0,0,0, 6'b000100, "basic");
        add(0,0,0, 0,0,0, 6'b110100, "basic_rise2");
        add(0,0,0, 0,0,0, 6'b100100, "basic");
        add(0,0,0, 0,0,0, 6'b001100, "basic_fall2");
        add(0,0,0, 0,0,0, 6'b000100, "basic");
        add(0,0,0, 0,0,0, 6'b000100, "basic");
        add(0,0,0, 0,0,0, 6'b000010, "basic_done");
        add(0,0,0, 0,0,0, 6'b000000, "basic_idle");
        // Minimum H=L=1, N=4
        add(0,1,0, 1,1,4, 6'b110100, "min");
        for (int i = 0; i < 3; i++) begin
            add(0,0,0, 1,1,4, 6'b001100, "min_fall");
            add(0,0,0, 1,1,4, 6'b110100, "min_rise");
        end
        add(0,0,0, 1,1,4, 6'b001100, "min_fall");
        add(0,0,0, 1,1,4, 6'b000010, "min_done");
        // Rejections
        add(0,1,0, 2,3,0, 6'b000001, "rej_rep0");
        add(0,0,0, 2,3,0, 6'b000000, "rej_rep0_after");
        add(0,1,0, 0,3,1, 6'b000001, "rej_high0");
        add(0,1,0, 2,0,1, 6'b000001, "rej_low0");
        add(0,1,1, 2,3,1, 6'b000000, "start_stop");
        add(0,0,0, 2,3,1, 6'b000000, "start_stop_after");
        add(0,1,1, 2,3,0, 6'b000000, "start_stop_bad");

        foreach (vecs[i]) begin
            rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
            high_len = vecs[i].h; low_len = vecs[i].l; repeat_n = vecs[i].n;
            cyc();
            check(vecs[i].name, 32'(o), 32'(vecs[i].want));
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        cyc();

        // Abort on the 2nd high cycle of H=4 L=4 N=3
        go(4, 4, 3);
        cyc();
        start = 1'b0;
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("abort_next", 32'(o), 32'(6'b001000));
        begin
            int bad = 0;
            for (int i = 0; i < 40; i++) begin
                cyc();
                if (done || busy || dout) bad++;
            end
            check("abort_quiet", 32'(bad), 32'd0);
        end

        // Back-to-back with detector loopback: H=2 L=3 N=1 twice
        begin
            int   det_r = 0, det_f = 0, lag_bad = 0, waited;
            logic pr = 1'b0, pf = 1'b0;
            go(2, 3, 1);
            cyc();
            start = 1'b0;
            waited = 0;
            while (!done && waited < 50) begin
                if (det_rise !== pr || det_fall !== pf) lag_bad++;
                det_r += int'(det_rise); det_f += int'(det_fall);
                pr = rise_strb; pf = fall_strb;
                cyc();
                waited++;
            end
            check("b2b_done1_seen", 32'(done), 32'd1);
            go(2, 3, 1);
            for (int i = 0; i < 10; i++) begin
                if (det_rise !== pr || det_fall !== pf) lag_bad++;
                det_r += int'(det_rise); det_f += int'(det_fall);
                pr = rise_strb; pf = fall_strb;
                cyc();
                start = 1'b0;
                if (i == 0) check("b2b_immediate_rise", 32'({dout, rise_strb}), 32'(2'b11));
            end
            check("b2b_det_lag", 32'(lag_bad), 32'd0);
            check("b2b_det_rises", 32'(det_r), 32'd2);
            check("b2b_det_falls", 32'(det_f), 32'd2);
        end

        // Maximum lengths: H=L=255, N=2 -> done exactly 1021 cycles after start
        begin
            int hi = 0, rs = 0, fs = 0, done_at = -1;
            go(255, 255, 2);
            for (int c = 1; c <= 1030; c++) begin
                cyc();
                start = 1'b0;
                hi += int'(dout); rs += int'(rise_strb); fs += int'(fall_strb);
                if (done && done_at < 0) done_at = c;
            end
            check("max_high_cycles", 32'(hi), 32'd510);
            check("max_rises", 32'(rs), 32'd2);
            check("max_falls", 32'(fs), 32'd2);
            check("max_done_time", 32'(done_at), 32'd1021);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
